pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline control block for the 5-stage MIPS core (IF, ID, EX, MEM, WB). It replaces the bare external `flush` with tracked per-stage valid/tag state. From that state it generates stall, flush, bubble and forwarding controls for load-use hazards, RAW hazards, a multi-cycle EX unit and a variable-latency data memory. It sits beside the four pipeline registers and drives their enables and bubble inputs.

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: stage record layout, forwarding select encodings, stall-cause
// enumeration and the forwarding priority helper used by pipe_hazard_ctrl.
// Ports: none (package).

package pipe_pkg;

  // Register-address width held in stage records. The top zero-extends its
  // AW-wide addresses into this field, so AW must not exceed RA_W.
  localparam int RA_W = 8;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            use_rs;
    logic            use_rt;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
  } stage_tag_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [2:0] {
    NONE,
    LOADUSE,
    RAW,
    EXBUSY,
    MEMWAIT
  } stall_cause_t;

  // MEM wins over WB, but a load in MEM has no data yet, so it cannot forward.
  function automatic logic [1:0] fwd_pick(logic mem_dep, logic mem_is_load, logic wb_dep);
    if (mem_dep && !mem_is_load) return FWD_MEM;
    else if (wb_dep)             return FWD_WB;
    else                         return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - single producer/consumer register dependency comparator
//
// Purpose: flags that a consumer operand depends on the result of a producer
// stage. Register 0 never creates a dependency.
// Ports:
//   valid_i     producer stage holds a real instruction
//   regwrite_i  producer writes the register file
//   rd_i        producer destination register
//   reg_i       consumer source register
//   use_i       consumer actually reads reg_i
//   dep_o       dependency present

module hazard_detect #(
  parameter int AW = 5
) (
  input  logic          valid_i,
  input  logic          regwrite_i,
  input  logic [AW-1:0] rd_i,
  input  logic [AW-1:0] reg_i,
  input  logic          use_i,
  output logic          dep_o
);

  assign dep_o = valid_i & regwrite_i & use_i & (reg_i != '0) & (rd_i == reg_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/bubble/forwarding control for a 5-stage pipeline
//
// Purpose: tracks EX/MEM/WB instruction records and derives pipeline register
// enables, bubbles, operand forwarding and register-file write control.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   id_valid, id_rs, id_rt            ID instruction and its source registers
//   id_use_rs, id_use_rt              ID reads rs / rt
//   id_rd, id_regwrite                ID destination and write flag
//   id_memread, id_memwrite           ID is a load / store
//   id_branch_taken                   branch resolved taken in ID
//   ex_busy, dmem_ready               multi-cycle EX busy, data memory done
//   pc_en, ifid_en, ifid_flush        front-end control
//   idex_en, exmem_en, memwb_en       pipeline register enables
//   idex_bubble, exmem_bubble,
//   memwb_bubble                      pipeline register bubble inserts
//   fwd_a, fwd_b                      EX operand source selects
//   wb_en, wb_rd                      register file write port control
//   stall_cnt                         saturating count of stalled cycles

module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int AW     = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_branch_taken,
  input  logic             ex_busy,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             wb_en,
  output logic [AW-1:0]    wb_rd,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_tag_t id_tag;
  stage_tag_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  stall_cause_t cause;

  always_comb begin
    id_tag          = '0;
    id_tag.valid    = id_valid;
    id_tag.rd       = RA_W'(id_rd);
    id_tag.rs       = RA_W'(id_rs);
    id_tag.rt       = RA_W'(id_rt);
    id_tag.use_rs   = id_use_rs;
    id_tag.use_rt   = id_use_rt;
    id_tag.regwrite = id_regwrite;
    id_tag.memread  = id_memread;
    id_tag.memwrite = id_memwrite;
  end

  // Producer view of the three tracked stages: index 0 = EX, 1 = MEM, 2 = WB.
  logic [2:0]      src_valid, src_regwrite;
  logic [RA_W-1:0] src_rd [3];

  assign src_valid    = {wb_q.valid, mem_q.valid, ex_q.valid};
  assign src_regwrite = {wb_q.regwrite, mem_q.regwrite, ex_q.regwrite};
  assign src_rd[0]    = ex_q.rd;
  assign src_rd[1]    = mem_q.rd;
  assign src_rd[2]    = wb_q.rd;

  logic [2:0] dep_id_rs, dep_id_rt;
  logic [1:0] dep_ex_rs, dep_ex_rt;

  // ID operands against EX, MEM and WB producers.
  for (genvar s = 0; s < 3; s++) begin : g_id_dep
    hazard_detect #(.AW(RA_W)) u_rs (
      .valid_i    (src_valid[s]),
      .regwrite_i (src_regwrite[s]),
      .rd_i       (src_rd[s]),
      .reg_i      (id_tag.rs),
      .use_i      (id_tag.use_rs),
      .dep_o      (dep_id_rs[s])
    );
    hazard_detect #(.AW(RA_W)) u_rt (
      .valid_i    (src_valid[s]),
      .regwrite_i (src_regwrite[s]),
      .rd_i       (src_rd[s]),
      .reg_i      (id_tag.rt),
      .use_i      (id_tag.use_rt),
      .dep_o      (dep_id_rt[s])
    );
  end

  // EX operands against MEM and WB producers, for forwarding.
  for (genvar s = 1; s < 3; s++) begin : g_ex_dep
    hazard_detect #(.AW(RA_W)) u_rs (
      .valid_i    (src_valid[s]),
      .regwrite_i (src_regwrite[s]),
      .rd_i       (src_rd[s]),
      .reg_i      (ex_q.rs),
      .use_i      (ex_q.use_rs),
      .dep_o      (dep_ex_rs[s-1])
    );
    hazard_detect #(.AW(RA_W)) u_rt (
      .valid_i    (src_valid[s]),
      .regwrite_i (src_regwrite[s]),
      .rd_i       (src_rd[s]),
      .reg_i      (ex_q.rt),
      .use_i      (ex_q.use_rt),
      .dep_o      (dep_ex_rt[s-1])
    );
  end

  logic mem_stall, ex_stall, load_stall, raw_stall;

  assign mem_stall  = mem_q.valid & (mem_q.memread | mem_q.memwrite) & ~dmem_ready;
  assign ex_stall   = ex_q.valid & ex_busy;
  assign load_stall = id_valid & ex_q.memread & (dep_id_rs[0] | dep_id_rt[0]);
  // Without forwarding the register file is not write-through, so even a WB
  // producer must drain before ID can read its operands.
  assign raw_stall  = (FWD_EN == 0) && id_valid && ((|dep_id_rs) || (|dep_id_rt));

  always_comb begin
    cause = NONE;
    if (mem_stall)       cause = MEMWAIT;
    else if (ex_stall)   cause = EXBUSY;
    else if (load_stall) cause = LOADUSE;
    else if (raw_stall)  cause = RAW;
  end

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    unique case (cause)
      MEMWAIT: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
      end
      EXBUSY: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_bubble = 1'b1;
      end
      LOADUSE, RAW: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_bubble  = 1'b1;
      end
      default: ;
    endcase
    // A stalled branch is simply re-presented by ID next cycle; only an
    // advancing branch squashes the fetched instruction.
    ifid_flush = (cause == NONE) & id_branch_taken;

    if (rst) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (FWD_EN != 0 && !rst) begin
      fwd_a = fwd_pick(dep_ex_rs[0], mem_q.memread, dep_ex_rs[1]);
      fwd_b = fwd_pick(dep_ex_rt[0], mem_q.memread, dep_ex_rt[1]);
    end
  end

  assign wb_en     = ~rst & wb_q.valid & wb_q.regwrite & (wb_q.rd != '0);
  assign wb_rd     = rst ? '0 : wb_q.rd[AW-1:0];
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (idex_en)  ex_d  = idex_bubble  ? stage_tag_t'('0) : id_tag;
    if (exmem_en) mem_d = exmem_bubble ? stage_tag_t'('0) : ex_q;
    if (memwb_en) wb_d  = memwb_bubble ? stage_tag_t'('0) : mem_q;

    stall_cnt_d = stall_cnt_q;
    if (cause != NONE && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Records carry every field through all stages; later stages only look at
  // some of them.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, id_memwrite;
  logic       id_branch_taken, ex_busy, dmem_ready;
  logic [4:0] id_rs, id_rt, id_rd;

  logic       pc_en_1, ifid_en_1, ifid_flush_1, idex_en_1, exmem_en_1, memwb_en_1;
  logic       idex_bubble_1, exmem_bubble_1, memwb_bubble_1, wb_en_1;
  logic [1:0] fwd_a_1, fwd_b_1;
  logic [4:0] wb_rd_1;
  logic [15:0] stall_cnt_1;

  logic       pc_en_0, ifid_en_0, ifid_flush_0, idex_en_0, exmem_en_0, memwb_en_0;
  logic       idex_bubble_0, exmem_bubble_0, memwb_bubble_0, wb_en_0;
  logic [1:0] fwd_a_0, fwd_b_0;
  logic [4:0] wb_rd_0;
  logic [3:0] stall_cnt_0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.AW(5), .FWD_EN(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch_taken(id_branch_taken),
    .ex_busy(ex_busy), .dmem_ready(dmem_ready), .pc_en(pc_en_1), .ifid_en(ifid_en_1),
    .ifid_flush(ifid_flush_1), .idex_en(idex_en_1), .exmem_en(exmem_en_1), .memwb_en(memwb_en_1),
    .idex_bubble(idex_bubble_1), .exmem_bubble(exmem_bubble_1), .memwb_bubble(memwb_bubble_1),
    .fwd_a(fwd_a_1), .fwd_b(fwd_b_1), .wb_en(wb_en_1), .wb_rd(wb_rd_1), .stall_cnt(stall_cnt_1)
  );

  pipe_hazard_ctrl #(.AW(5), .FWD_EN(0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch_taken(id_branch_taken),
    .ex_busy(ex_busy), .dmem_ready(dmem_ready), .pc_en(pc_en_0), .ifid_en(ifid_en_0),
    .ifid_flush(ifid_flush_0), .idex_en(idex_en_0), .exmem_en(exmem_en_0), .memwb_en(memwb_en_0),
    .idex_bubble(idex_bubble_0), .exmem_bubble(exmem_bubble_0), .memwb_bubble(memwb_bubble_0),
    .fwd_a(fwd_a_0), .fwd_b(fwd_b_0), .wb_en(wb_en_0), .wb_rd(wb_rd_0), .stall_cnt(stall_cnt_0)
  );

  logic [18:0] obs_1, obs_0;
  assign obs_1 = {pc_en_1, ifid_en_1, ifid_flush_1, idex_en_1, exmem_en_1, memwb_en_1,
                  idex_bubble_1, exmem_bubble_1, memwb_bubble_1, fwd_a_1, fwd_b_1, wb_en_1, wb_rd_1};
  assign obs_0 = {pc_en_0, ifid_en_0, ifid_flush_0, idex_en_0, exmem_en_0, memwb_en_0,
                  idex_bubble_0, exmem_bubble_0, memwb_bubble_0, fwd_a_0, fwd_b_0, wb_en_0, wb_rd_0};

  // Reference model: one instruction list per DUT, [0]=EX [1]=MEM [2]=WB.
  // Index 1 models the forwarding DUT, index 0 the non-forwarding DUT.
  typedef struct {
    bit       v;
    bit [4:0] rd, rs, rt;
    bit       urs, urt, rw, mr, mw;
  } ins_t;

  ins_t        st [2][3];
  int unsigned cnt [2];
  int unsigned cnt_max [2] = '{15, 65535};
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic ins_t id_ins();
    ins_t i;
    i.v = id_valid; i.rd = id_rd; i.rs = id_rs; i.rt = id_rt;
    i.urs = id_use_rs; i.urt = id_use_rt; i.rw = id_regwrite; i.mr = id_memread; i.mw = id_memwrite;
    return i;
  endfunction

  function automatic ins_t nop_ins();
    ins_t i;
    i.v = 0; i.rd = 0; i.rs = 0; i.rt = 0; i.urs = 0; i.urt = 0; i.rw = 0; i.mr = 0; i.mw = 0;
    return i;
  endfunction

  function automatic bit dep(ins_t p, bit [4:0] r, bit u);
    return p.v && p.rw && u && (r != 0) && (p.rd == r);
  endfunction

  // 3 = memory wait, 2 = EX busy, 1 = ID hazard, 0 = flowing.
  function automatic int level(int d);
    ins_t id = id_ins();
    if (st[d][1].v && (st[d][1].mr || st[d][1].mw) && !dmem_ready) return 3;
    if (st[d][0].v && ex_busy) return 2;
    if (id.v && st[d][0].mr && (dep(st[d][0], id.rs, id.urs) || dep(st[d][0], id.rt, id.urt))) return 1;
    if (d == 0 && id.v)
      for (int k = 0; k < 3; k++)
        if (dep(st[d][k], id.rs, id.urs) || dep(st[d][k], id.rt, id.urt)) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] fwd_model(int d, bit [4:0] r, bit u);
    if (d == 0) return 2'b00;
    if (dep(st[d][1], r, u) && !st[d][1].mr) return 2'b01;
    if (dep(st[d][2], r, u)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [18:0] exp_vec(int d);
    int   l = level(d);
    ins_t w = st[d][2];
    if (rst) return {9'b001000111, 2'b00, 2'b00, 1'b0, 5'd0};
    return {l == 0, l == 0, (l == 0) && id_branch_taken, l <= 1, l <= 2, 1'b1,
            l == 1, l == 2, l == 3,
            fwd_model(d, st[d][0].rs, st[d][0].urs), fwd_model(d, st[d][0].rt, st[d][0].urt),
            w.v && w.rw && (w.rd != 0), w.rd};
  endfunction

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int k = 0; k < 3; k++) st[d][k] = nop_ins();
        cnt[d] = 0;
      end else begin
        int l = level(d);
        if (l != 0 && cnt[d] < cnt_max[d]) cnt[d]++;
        case (l)
          3: st[d][2] = nop_ins();
          2: begin st[d][2] = st[d][1]; st[d][1] = nop_ins(); end
          1: begin st[d][2] = st[d][1]; st[d][1] = st[d][0]; st[d][0] = nop_ins(); end
          default: begin st[d][2] = st[d][1]; st[d][1] = st[d][0]; st[d][0] = id_ins(); end
        endcase
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [18:0] e;
    @(negedge clk);
    e = exp_vec(1);
    n_cmp++;
    assert (obs_1 === e) else begin
      n_fail++;
      $error("FAIL outputs_fwd1 observed=%h expected=%h", obs_1, e);
    end
    e = exp_vec(0);
    n_cmp++;
    assert (obs_0 === e) else begin
      n_fail++;
      $error("FAIL outputs_fwd0 observed=%h expected=%h", obs_0, e);
    end
    chk("stall_cnt_fwd1", stall_cnt_1, 16'(cnt[1]));
    chk("stall_cnt_fwd0", {12'd0, stall_cnt_0}, 16'(cnt[0]));
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic set_id(bit v, int rs, int rt, bit urs, bit urt, int rd, bit rw, bit mr, bit mw, bit br);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_rd = 5'(rd); id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_branch_taken = br;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; dmem_ready = 1'b1; ex_busy = 1'b0;
    nop();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    bit held;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) st[d][k] = nop_ins();
      cnt[d] = 0;
    end
    rst = 1'b1; dmem_ready = 1'b1; ex_busy = 1'b0;
    nop();
    adv();

    // Reset state
    sample();
    chk("rst_pc_en", pc_en_1, 0);
    chk("rst_ifid_flush", ifid_flush_1, 1);
    chk("rst_cnt", stall_cnt_1, 0);
    adv();
    rst = 1'b0;

    // lw $2 ; add $3,$2,$4
    do_reset();
    set_id(1, 1, 2, 1, 0, 2, 1, 1, 0, 0); cyc();
    set_id(1, 2, 4, 1, 1, 3, 1, 0, 0, 0);
    sample(); chk("lu_pc_en", pc_en_1, 0); chk("lu_idex_bubble", idex_bubble_1, 1); adv();
    sample(); chk("lu_release", pc_en_1, 1); adv();
    nop();
    sample(); chk("lu_fwd_a", fwd_a_1, 2'b10); chk("lu_cnt", stall_cnt_1, 1); adv();

    // add $5,$1,$1 ; sub $6,$5,$5 with forwarding
    do_reset();
    set_id(1, 1, 1, 1, 1, 5, 1, 0, 0, 0); cyc();
    set_id(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    sample(); chk("fw_no_stall", pc_en_1, 1); adv();
    nop();
    sample(); chk("fw_a", fwd_a_1, 2'b01); chk("fw_b", fwd_b_1, 2'b01); chk("fw_cnt", stall_cnt_1, 0); adv();

    // same pair without forwarding: ID held through three RAW stalls
    do_reset();
    set_id(1, 1, 1, 1, 1, 5, 1, 0, 0, 0); cyc();
    set_id(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sample(); chk("raw_pc_en", pc_en_0, 0); adv();
    end
    sample(); chk("raw_release", pc_en_0, 1); chk("raw_cnt", {12'd0, stall_cnt_0}, 3); adv();
    nop(); cyc();
    sample(); chk("raw_fwd_a", fwd_a_0, 2'b00); adv();

    // taken branch, then taken branch held behind a load-use stall
    do_reset();
    set_id(1, 1, 2, 1, 1, 0, 0, 0, 0, 1);
    sample(); chk("br_flush", ifid_flush_1, 1); chk("br_pc_en", pc_en_1, 1); adv();
    nop();
    sample(); chk("br_flush_one", ifid_flush_1, 0); adv();
    set_id(1, 1, 2, 1, 0, 2, 1, 1, 0, 0); cyc();
    set_id(1, 2, 3, 1, 1, 0, 0, 0, 0, 1);
    sample(); chk("br_held", ifid_flush_1, 0); chk("br_held_pc", pc_en_1, 0); adv();
    sample(); chk("br_late_flush", ifid_flush_1, 1); adv();

    // sw waits on memory for 4 cycles while EX is busy too
    do_reset();
    set_id(1, 1, 4, 1, 1, 0, 0, 0, 1, 0); cyc();
    set_id(1, 1, 1, 1, 1, 7, 1, 0, 0, 0); cyc();
    nop(); dmem_ready = 1'b0; ex_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("mw_memwb_bubble", memwb_bubble_1, 1);
      chk("mw_pc_en", pc_en_1, 0);
      chk("mw_exmem_bubble", exmem_bubble_1, 0);
      adv();
    end
    dmem_ready = 1'b1; ex_busy = 1'b0;
    sample(); chk("mw_cnt", stall_cnt_1, 4); chk("mw_done", memwb_bubble_1, 0); adv();

    // writes to $0 never forward, stall or write back
    do_reset();
    set_id(1, 1, 1, 1, 1, 0, 1, 0, 0, 0); cyc();
    set_id(1, 0, 0, 1, 1, 8, 1, 0, 0, 0);
    sample(); chk("r0_pc_en_fwd1", pc_en_1, 1); chk("r0_pc_en_fwd0", pc_en_0, 1); adv();
    nop();
    sample(); chk("r0_fwd_a", fwd_a_1, 0); chk("r0_fwd_b", fwd_b_1, 0); adv();
    sample(); chk("r0_wb_en", wb_en_1, 0); adv();

    // reset asserted in the middle of a memory stall
    do_reset();
    set_id(1, 1, 4, 1, 1, 0, 0, 0, 1, 0); cyc();
    nop(); cyc();
    dmem_ready = 1'b0;
    sample(); chk("rm_stall", memwb_bubble_1, 1); adv();
    rst = 1'b1;
    sample(); chk("rm_pc_en", pc_en_1, 0); chk("rm_flush", ifid_flush_1, 1); adv();
    rst = 1'b0;
    sample();
    chk("rm_cnt", stall_cnt_1, 0);
    chk("rm_no_stall", memwb_bubble_1, 0);
    chk("rm_pc_en_after", pc_en_1, 1);
    adv();
    dmem_ready = 1'b1;

    // randomized traffic; ID is held while the forwarding DUT stalls
    do_reset();
    held = 0;
    for (int i = 0; i < 800; i++) begin
      if (!held) begin
        set_id($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 4) == 0);
      end
      ex_busy    = ($urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 149) == 0);
      sample();
      held = !rst && (level(1) != 0);
      adv();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
